// File: rtl/outport_pkg.sv
// outport_pkg: frame state encoding, flush depth and length clamp shared by the output-port framer.
// DATA_WIDTH is normally supplied by mpcache.svh; the guarded default keeps this slice self-contained.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package outport_pkg;
    typedef enum logic [2:0] {IDLE, SOP, READ, FLUSH, EOP, GAP} frame_state_e;
    localparam int FLUSH_CYCLES = 2;
    function automatic int len_clamp(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction
endpackage

// File: rtl/outport_frame_gen.sv
// outport_frame_gen: frames one descriptor's worth of SRAM words as sop / data beats / eop.
// Optional OUTPORT_FRAME_STATS_EN adds packet and word counters.
module outport_frame_gen
    import outport_pkg::*;
#(
    parameter int CHANNEL_IDX = 0,
    parameter int LEN_WIDTH   = 8,
    parameter int MAX_LEN     = 128,
    parameter int IPG         = 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   i_desc_vld,
    input  logic [LEN_WIDTH-1:0]   i_desc_len,
    output logic                   o_desc_ack,
    output logic                   o_rd_en,
    input  logic [`DATA_WIDTH-1:0] i_rd_data,
    output logic                   o_sop,
    output logic                   o_vld,
    output logic [`DATA_WIDTH-1:0] o_data,
    output logic                   o_eop,
    output logic                   o_busy,
`ifdef OUTPORT_FRAME_STATS_EN
    output logic                   o_len_err,
    output logic [31:0]            o_pkt_cnt,
    output logic [31:0]            o_word_cnt
`else
    output logic                   o_len_err
`endif
);
    if (CHANNEL_IDX < 0 || CHANNEL_IDX > 15) begin : g_bad_channel
        $error("outport_frame_gen: CHANNEL_IDX out of range 0..15");
    end

    frame_state_e           r_state, w_next;
    logic [LEN_WIDTH:0]     r_cnt;
    logic [15:0]            r_tmr;
    logic                   r_rd_q, r_vld, r_len_err;
    logic [`DATA_WIDTH-1:0] r_data;
    logic                   w_ack, w_bad;

    assign w_bad      = (i_desc_len == '0) || (int'(i_desc_len) > MAX_LEN);
    assign o_desc_ack = w_ack;
    assign o_vld      = r_vld;
    assign o_data     = r_data;
    assign o_len_err  = r_len_err;

    // State register; r_tmr restarts on every state change and times FLUSH and GAP
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_next;
            r_tmr   <= (w_next != r_state) ? '0 : r_tmr + 1'b1;
        end
    end

    // Next state: reads run from SOP until the counter's last word, then drain the read pipe
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_ack) w_next = SOP;
            SOP:     w_next = (r_cnt == '0) ? EOP : (r_cnt == (LEN_WIDTH+1)'(1)) ? FLUSH : READ;
            READ:    if (r_cnt == (LEN_WIDTH+1)'(1)) w_next = FLUSH;
            FLUSH:   if (r_tmr == 16'(FLUSH_CYCLES - 1)) w_next = EOP;
            EOP:     w_next = (IPG == 0) ? IDLE : GAP;
            GAP:     if (r_tmr == 16'(IPG - 1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes decoded from state; ack is suppressed while reset would discard it anyway
    always_comb begin
        w_ack   = (r_state == IDLE) && i_desc_vld && !rst_in;
        o_sop   = (r_state == SOP);
        o_rd_en = ((r_state == SOP) || (r_state == READ)) && (r_cnt != '0);
        o_eop   = (r_state == EOP);
        o_busy  = (r_state != IDLE);
    end

    // Read countdown, one-cycle read-latency alignment, beat register and length error pulse
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt     <= '0;
            r_rd_q    <= 1'b0;
            r_vld     <= 1'b0;
            r_data    <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_rd_q    <= o_rd_en;
            r_vld     <= r_rd_q;
            r_len_err <= w_ack && w_bad;
            if (r_rd_q) r_data <= i_rd_data;
            if (w_ack) r_cnt <= (LEN_WIDTH+1)'(len_clamp(int'(i_desc_len), MAX_LEN));
            else if (o_rd_en) r_cnt <= r_cnt - 1'b1;
        end
    end

`ifdef OUTPORT_FRAME_STATS_EN
    // Free-running wrap-around packet and word counters
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            o_pkt_cnt  <= '0;
            o_word_cnt <= '0;
        end else begin
            if (o_eop) o_pkt_cnt <= o_pkt_cnt + 1'b1;
            if (r_vld) o_word_cnt <= o_word_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_outport_frame_gen.sv
// tb_outport_frame_gen: directed checks of framing timing, length edge cases, IPG and mid-packet reset.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module tb_outport_frame_gen;
    localparam int DW = `DATA_WIDTH;

    logic clk = 1'b0;
    logic rst;
    logic a_desc_vld, a_ack, a_rd_en, a_sop, a_vld, a_eop, a_busy, a_len_err;
    logic b_desc_vld, b_ack, b_rd_en, b_sop, b_vld, b_eop, b_busy, b_len_err;
    logic [7:0] a_desc_len, b_desc_len;
    logic [DW-1:0] a_rd_data, a_data, b_rd_data, b_data, a_base, b_base;
`ifdef OUTPORT_FRAME_STATS_EN
    logic [31:0] a_pkt_cnt, a_word_cnt, b_pkt_cnt, b_word_cnt;
`endif
    int n_cmp = 0, n_bad = 0;
    int a_rd_cnt = 0, a_beat = 0, a_eop_cnt = 0;
    int b_rd_cnt = 0, b_beat = 0, b_eop_cnt = 0;

    always #5 clk = ~clk;

    outport_frame_gen #(.CHANNEL_IDX(0), .LEN_WIDTH(8), .MAX_LEN(128), .IPG(1)) u_a (
        .clk_in(clk), .rst_in(rst), .i_desc_vld(a_desc_vld), .i_desc_len(a_desc_len),
        .o_desc_ack(a_ack), .o_rd_en(a_rd_en), .i_rd_data(a_rd_data), .o_sop(a_sop),
        .o_vld(a_vld), .o_data(a_data), .o_eop(a_eop), .o_busy(a_busy),
`ifdef OUTPORT_FRAME_STATS_EN
        .o_pkt_cnt(a_pkt_cnt), .o_word_cnt(a_word_cnt),
`endif
        .o_len_err(a_len_err)
    );

    outport_frame_gen #(.CHANNEL_IDX(1), .LEN_WIDTH(8), .MAX_LEN(128), .IPG(0)) u_b (
        .clk_in(clk), .rst_in(rst), .i_desc_vld(b_desc_vld), .i_desc_len(b_desc_len),
        .o_desc_ack(b_ack), .o_rd_en(b_rd_en), .i_rd_data(b_rd_data), .o_sop(b_sop),
        .o_vld(b_vld), .o_data(b_data), .o_eop(b_eop), .o_busy(b_busy),
`ifdef OUTPORT_FRAME_STATS_EN
        .o_pkt_cnt(b_pkt_cnt), .o_word_cnt(b_word_cnt),
`endif
        .o_len_err(b_len_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: SRAM model answers last cycle's pop, then beats/eops are tallied and checked
    task automatic step();
        logic ra, rb;
        ra = a_rd_en;
        rb = b_rd_en;
        @(posedge clk);
        #1;
        a_rd_data = (ra === 1'b1) ? a_base + DW'(a_rd_cnt) : DW'(32'hDEADBEEF);
        b_rd_data = (rb === 1'b1) ? b_base + DW'(b_rd_cnt) : DW'(32'hDEADBEEF);
        if (ra === 1'b1) a_rd_cnt++;
        if (rb === 1'b1) b_rd_cnt++;
        if (a_vld === 1'b1) begin
            chk("a_beat_data", 64'(a_data), 64'(a_base + DW'(a_beat)));
            a_beat++;
        end
        if (b_vld === 1'b1) begin
            chk("b_beat_data", 64'(b_data), 64'(b_base + DW'(b_beat)));
            b_beat++;
        end
        if (a_eop === 1'b1) a_eop_cnt++;
        if (b_eop === 1'b1) b_eop_cnt++;
        chk("a_excl", 64'((32'(a_sop) + 32'(a_vld) + 32'(a_eop)) <= 1), 1);
        chk("b_excl", 64'((32'(b_sop) + 32'(b_vld) + 32'(b_eop)) <= 1), 1);
    endtask

    task automatic clr_a(input logic [DW-1:0] base);
        a_base = base; a_rd_cnt = 0; a_beat = 0; a_eop_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        a_desc_vld = 1'b0; a_desc_len = '0; b_desc_vld = 1'b0; b_desc_len = '0;
        a_base = DW'(32'hA0); b_base = DW'(32'hB0);
        a_rd_data = '0; b_rd_data = '0;
        repeat (2) step();
        chk("rst_sop", a_sop, 0); chk("rst_vld", a_vld, 0); chk("rst_eop", a_eop, 0);
        chk("rst_rd_en", a_rd_en, 0); chk("rst_busy", a_busy, 0);
        chk("rst_len_err", a_len_err, 0); chk("rst_data", 64'(a_data), 0);
        rst = 1'b0;
        step();
        clr_a(DW'(32'hA0));

        // L=4, IPG=1: sop 1, rd 1..4, beats 3..6, eop 7, next ack at 9
        a_desc_vld = 1'b1; a_desc_len = 8'd4;
        #1 chk("t1_ack0", a_ack, 1);
        step();
        a_desc_vld = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 8) begin a_desc_vld = 1'b1; a_desc_len = 8'd1; end
            #1;
            chk($sformatf("t1_sop_c%0d", c), a_sop, 64'(c == 1));
            chk($sformatf("t1_rd_c%0d", c), a_rd_en, 64'(c <= 4));
            chk($sformatf("t1_vld_c%0d", c), a_vld, 64'(c >= 3 && c <= 6));
            chk($sformatf("t1_eop_c%0d", c), a_eop, 64'(c == 7));
            chk($sformatf("t1_busy_c%0d", c), a_busy, 64'(c <= 8));
            chk($sformatf("t1_ack_c%0d", c), a_ack, 64'(c == 9));
            chk($sformatf("t1_lerr_c%0d", c), a_len_err, 0);
            if (c == 7) chk("t1_hold_data", 64'(a_data), 64'(32'hA3));
            step();
            if (c == 9) a_desc_vld = 1'b0;
        end
        repeat (5) step();
        chk("t1_rd_total", 64'(a_rd_cnt), 5);
        chk("t1_beats", 64'(a_beat), 5);
        chk("t1_eops", 64'(a_eop_cnt), 2);
        chk("t1_idle", a_busy, 0);

        // Back-to-back L=2 then L=3 with IPG=0: second ack at cycle 6, eop of second at 12
        b_desc_vld = 1'b1; b_desc_len = 8'd2;
        #1 chk("t2_ack0", b_ack, 1);
        step();
        b_desc_len = 8'd3;
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk($sformatf("t2_ack_c%0d", c), b_ack, 64'(c == 6));
            chk($sformatf("t2_eop_c%0d", c), b_eop, 64'(c == 5));
            step();
        end
        b_desc_vld = 1'b0;
        repeat (6) step();
        chk("t2_eop_last", b_eop, 0);
        chk("t2_rd_total", 64'(b_rd_cnt), 5);
        chk("t2_beats", 64'(b_beat), 5);
        chk("t2_eops", 64'(b_eop_cnt), 2);
        chk("t2_idle", b_busy, 0);

        // L=0: sop 1 with len_err, eop 2, no reads
        clr_a(DW'(32'hC0));
        a_desc_vld = 1'b1; a_desc_len = 8'd0;
        #1 chk("t3_ack", a_ack, 1);
        step();
        a_desc_vld = 1'b0;
        #1;
        chk("t3_sop", a_sop, 1); chk("t3_lerr", a_len_err, 1); chk("t3_rd_en", a_rd_en, 0);
        step();
        #1;
        chk("t3_eop", a_eop, 1); chk("t3_lerr_off", a_len_err, 0); chk("t3_vld", a_vld, 0);
        repeat (2) step();
        chk("t3_rd_total", 64'(a_rd_cnt), 0);
        chk("t3_eops", 64'(a_eop_cnt), 1);
        chk("t3_idle", a_busy, 0);

        // L=200 clamps to 128: len_err at 1, 128 reads/beats, eop at 131
        clr_a(DW'(32'h1000));
        a_desc_vld = 1'b1; a_desc_len = 8'd200;
        #1 chk("t4_ack", a_ack, 1);
        step();
        a_desc_vld = 1'b0;
        #1;
        chk("t4_lerr", a_len_err, 1); chk("t4_sop", a_sop, 1); chk("t4_rd_en", a_rd_en, 1);
        repeat (130) step();
        #1;
        chk("t4_eop", a_eop, 1); chk("t4_vld", a_vld, 0);
        chk("t4_rd_total", 64'(a_rd_cnt), 128);
        chk("t4_beats", 64'(a_beat), 128);
        chk("t4_last_data", 64'(a_data), 64'(32'h1000 + 127));
        repeat (2) step();
        chk("t4_idle", a_busy, 0);

        // Reset during cycle 4 of L=8: all quiet next cycle, no eop, then L=1 frames cleanly
        clr_a(DW'(32'h2000));
        a_desc_vld = 1'b1; a_desc_len = 8'd8;
        step();
        a_desc_vld = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_sop", a_sop, 0); chk("t5_vld", a_vld, 0); chk("t5_eop", a_eop, 0);
        chk("t5_rd_en", a_rd_en, 0); chk("t5_busy", a_busy, 0);
        chk("t5_lerr", a_len_err, 0); chk("t5_data", 64'(a_data), 0);
        repeat (12) step();
        chk("t5_beats", 64'(a_beat), 2);
        chk("t5_eops", 64'(a_eop_cnt), 0);
        clr_a(DW'(32'h3000));
        a_desc_vld = 1'b1; a_desc_len = 8'd1;
        #1 chk("t5_ack", a_ack, 1);
        step();
        a_desc_vld = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk($sformatf("t5_sop_c%0d", c), a_sop, 64'(c == 1));
            chk($sformatf("t5_rd_c%0d", c), a_rd_en, 64'(c == 1));
            chk($sformatf("t5_vld_c%0d", c), a_vld, 64'(c == 3));
            chk($sformatf("t5_eop_c%0d", c), a_eop, 64'(c == 4));
            step();
        end
        chk("t5_new_beats", 64'(a_beat), 1);
        chk("t5_new_eops", 64'(a_eop_cnt), 1);

`ifdef OUTPORT_FRAME_STATS_EN
        // Stats: three packets L=1,2,3 after a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        clr_a(DW'(32'h4000));
        for (int k = 1; k <= 3; k++) begin
            a_desc_vld = 1'b1; a_desc_len = 8'(k);
            step();
            a_desc_vld = 1'b0;
            repeat (10) step();
        end
        chk("t6_pkt_cnt", 64'(a_pkt_cnt), 3);
        chk("t6_word_cnt", 64'(a_word_cnt), 6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/outport_frame_gen.md
Name: outport_frame_gen

Overview:
- Per-channel output-port framer. Takes one packet descriptor (word length) from the output queue scheduler and pops that many words from the channel's SRAM read path (1-cycle read latency).
- Emits them on the codebase packet stream, the same stream the simulation print monitor consumes:
  - a standalone o_sop cycle,
  - o_vld/o_data beats,
  - a standalone o_eop cycle (eop never coincides with vld).
- Sits between the cache read controller and the output port / print monitor.

Parameters:
- CHANNEL_IDX, 0, output channel index (0..15); used only for identification and optional counters.
- LEN_WIDTH, 8, width of the descriptor length field, in words.
- MAX_LEN, 128, maximum legal packet length in words; larger lengths are clamped.
- IPG, 1, idle cycles inserted after o_eop before the next descriptor can be accepted (0 allowed).

Ports:
- clk_in  input  1  block clock.
- rst_in  input  1  synchronous active-high reset.
- i_desc_vld  input  1  packet descriptor valid.
- i_desc_len  input  LEN_WIDTH  packet length in words.
- o_desc_ack  output  1  descriptor accepted this cycle.
- o_rd_en  output  1  pop one word from the read path; data returns next cycle.
- i_rd_data  input  `DATA_WIDTH  read data, valid the cycle after o_rd_en.
- o_sop  output  1  start-of-packet strobe.
- o_vld  output  1  data beat valid.
- o_data  output  `DATA_WIDTH  data beat.
- o_eop  output  1  end-of-packet strobe.
- o_busy  output  1  packet in progress (state != IDLE).
- o_len_err  output  1  one-cycle pulse: zero or over-MAX_LEN length seen.

Behaviour:
- Clock and reset:
  - Single clock clk_in.
  - rst_in is synchronous and active-high.
  - Reset values: all outputs 0, o_data 0, state IDLE, counters 0.
- States: IDLE, SOP, READ, FLUSH, EOP, GAP.
- IDLE:
  - o_desc_ack = i_desc_vld (combinational, IDLE only).
  - On ack, latch len = (i_desc_len > MAX_LEN) ? MAX_LEN : i_desc_len, then go to SOP.
- Cycle timing, where cycle 0 is the ack cycle and L is the latched length:
  - Cycle 1 (SOP): o_sop = 1; o_rd_en = 1 if L > 0.
  - Cycles 1..L: o_rd_en = 1 (remaining state READ).
  - Then FLUSH for 2 cycles.
  - o_vld and o_data are registered from i_rd_data: beats appear in cycles 3..L+2, one per read, in order.
  - Cycle L+3: EOP, o_eop = 1, o_vld = 0.
  - Then GAP for IPG cycles, then IDLE. With IPG = 0, go straight to IDLE after EOP.
- Length edge cases:
  - L = 0: cycle 1 is SOP with no reads, then EOP in cycle 2. o_len_err pulses in cycle 1.
  - Clamp case (length > MAX_LEN): o_len_err pulses in cycle 1.
- Counting:
  - Read counter is LEN_WIDTH+1 bits and counts down.
  - o_rd_en deasserts in the cycle after the counter reaches 1.
- Hold and exclusivity rules:
  - o_data holds its last beat when o_vld = 0.
  - o_sop, o_vld and o_eop are mutually exclusive in every cycle.
- Descriptors: i_desc_vld while not IDLE is ignored; the descriptor must be held until acked.
- Reset mid-packet: next edge returns to IDLE with all strobes 0. No o_eop is emitted, and outstanding read data is discarded.
- Output has no backpressure: the downstream stage must accept every beat.

Optional Feature:
- Macro: OUTPORT_FRAME_STATS_EN.
- Defined:
  - Adds outputs o_pkt_cnt (32-bit, +1 on each o_eop) and o_word_cnt (32-bit, +1 on each o_vld).
  - Both counters wrap and reset to 0 on rst_in.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package outport_pkg holds:
  - frame_state_e enum (IDLE, SOP, READ, FLUSH, EOP, GAP);
  - FLUSH_CYCLES = 2 constant;
  - a len_clamp function.
- DATA_WIDTH comes from mpcache.svh.
- Sub-module: none required. The FSM and data register stay in one module.

Test Plan:
- L = 4, IPG = 1, data words A0..A3 → sop at cycle 1; rd_en cycles 1–4; vld beats A0..A3 at cycles 3–6; eop at cycle 7; next ack possible at cycle 9.
- Back-to-back descriptors L = 2, then L = 3, with IPG = 0 → second ack at cycle 6. No overlap of sop/vld/eop; 5 total beats in order.
- L = 0 → sop at cycle 1, eop at cycle 2, zero rd_en, o_len_err = 1 at cycle 1.
- L = 200 with MAX_LEN = 128 → exactly 128 rd_en and 128 beats, o_len_err pulse, then eop.
- rst_in asserted at cycle 4 of an L = 8 packet → all outputs 0 from the next cycle, no eop; a fresh L = 1 packet afterwards frames correctly.
- With OUTPORT_FRAME_STATS_EN: three packets L = 1, 2, 3 → o_pkt_cnt = 3, o_word_cnt = 6.
